// File: rtl/serial_div_ctrl.sv
// Unsigned restoring divider. The trial subtraction A - M runs bit-serially
// through one full-adder cell, one bit per clock. A host starts a division
// with start, watches busy, and collects quotient/remainder when done pulses.

// Single-bit full adder; the only arithmetic element in the divider.
module full_add (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule

module serial_div_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    // Counters must reach WIDTH (bit counter walks WIDTH+1 bits).
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        SUB,
        DECIDE,
        DONE
    } state_t;

    state_t         state;

    logic [WIDTH:0]   a_reg;     // partial remainder, one guard bit
    logic [WIDTH-1:0] q_reg;     // dividend shifting out, quotient shifting in
    logic [WIDTH:0]   m_reg;     // zero-extended divisor
    logic [WIDTH:0]   t_reg;     // trial difference A - M, built bit by bit
    logic             cy;        // serial carry; final value = no-borrow
    logic [CW-1:0]    it_cnt;    // quotient bits produced so far
    logic [CW-1:0]    bit_cnt;   // bit position inside the serial subtract

    logic             fa_a;
    logic             fa_b;
    logic             fa_sum;
    logic             fa_carry;

    logic [WIDTH:0]   a_next;
    logic [WIDTH-1:0] q_next;

    // Serial-subtract operands and the restore/commit decision values.
    always_comb begin
        fa_a   = a_reg[bit_cnt];
        fa_b   = ~m_reg[bit_cnt];
        a_next = cy ? t_reg : a_reg;
        q_next = {q_reg[WIDTH-1:1], cy};
    end

    // A + ~M + 1, one bit per clock, carry held in cy between bits.
    full_add u_fa (
        .a     (fa_a),
        .b     (fa_b),
        .c     (cy),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // Division sequencer with datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            a_reg       <= '0;
            q_reg       <= '0;
            m_reg       <= '0;
            t_reg       <= '0;
            cy          <= 1'b0;
            it_cnt      <= '0;
            bit_cnt     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        q_reg  <= dividend;
                        m_reg  <= {1'b0, divisor};
                        a_reg  <= '0;
                        it_cnt <= '0;
                        busy   <= 1'b1;
                        if (divisor == '0) begin
                            // Result registers load now so they are valid with done.
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            div_by_zero <= 1'b0;
                            state       <= SHIFT;
                        end
                    end
                end

                SHIFT: begin
                    a_reg   <= {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};
                    q_reg   <= {q_reg[WIDTH-2:0], 1'b0};
                    bit_cnt <= '0;
                    cy      <= 1'b1;
                    state   <= SUB;
                end

                SUB: begin
                    t_reg[bit_cnt] <= fa_sum;
                    cy             <= fa_carry;
                    bit_cnt        <= bit_cnt + CW'(1);
                    if (bit_cnt == CW'(WIDTH)) begin
                        state <= DECIDE;
                    end
                end

                DECIDE: begin
                    a_reg  <= a_next;
                    q_reg  <= q_next;
                    it_cnt <= it_cnt + CW'(1);
                    if (it_cnt == CW'(WIDTH - 1)) begin
                        // Load results from the next-state values so they
                        // appear in the same cycle as done.
                        quotient  <= q_next;
                        remainder <= a_next[WIDTH-1:0];
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state <= SHIFT;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_div_ctrl.sv
// Directed bench for serial_div_ctrl: vector table, exhaustive 4-bit sweep
// against a reference model, and hand-written multi-cycle corner sequences.
module tb_serial_div_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    logic       start8;
    logic [7:0] dividend8;
    logic [7:0] divisor8;
    logic       busy8;
    logic       done8;
    logic [7:0] quotient8;
    logic [7:0] remainder8;
    logic       div_by_zero8;

    int checks = 0;
    int errors = 0;

    serial_div_ctrl #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    serial_div_ctrl #(.WIDTH(8)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .start       (start8),
        .dividend    (dividend8),
        .divisor     (divisor8),
        .busy        (busy8),
        .done        (done8),
        .quotient    (quotient8),
        .remainder   (remainder8),
        .div_by_zero (div_by_zero8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] dd;
        logic [3:0] dv;
        logic [3:0] q;
        logic [3:0] r;
        logic       dz;
        int         cyc;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at #1 after a posedge with the DUT idle; returns at #1 after the
    // edge that ends the done cycle. Operands are scrambled after acceptance.
    task automatic do_div(input logic [3:0] dd, input logic [3:0] dv,
                          output logic [3:0] q, output logic [3:0] r,
                          output logic dz, output int dcyc, output int bcnt);
        start    = 1'b1;
        dividend = dd;
        divisor  = dv;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = dd ^ 4'hA;
        divisor  = dv ^ 4'h5;
        dcyc = -1;
        bcnt = 0;
        q    = '0;
        r    = '0;
        dz   = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                dcyc = n;
                q    = quotient;
                r    = remainder;
                dz   = div_by_zero;
                break;
            end
        end
        if (dcyc < 0) check("done timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[8];

    initial begin
        logic [3:0] q, r;
        logic       dz;
        int         dcyc, bcnt, ndone, first;
        logic [3:0] qv, rv;

        vecs[0] = '{dd: 4'd13, dv: 4'd3,  q: 4'd4,  r: 4'd1, dz: 1'b0, cyc: 29};
        vecs[1] = '{dd: 4'd15, dv: 4'd1,  q: 4'd15, r: 4'd0, dz: 1'b0, cyc: 29};
        vecs[2] = '{dd: 4'd7,  dv: 4'd9,  q: 4'd0,  r: 4'd7, dz: 1'b0, cyc: 29};
        vecs[3] = '{dd: 4'd0,  dv: 4'd5,  q: 4'd0,  r: 4'd0, dz: 1'b0, cyc: 29};
        vecs[4] = '{dd: 4'd9,  dv: 4'd0,  q: 4'hF,  r: 4'd9, dz: 1'b1, cyc: 1};
        vecs[5] = '{dd: 4'd8,  dv: 4'd2,  q: 4'd4,  r: 4'd0, dz: 1'b0, cyc: 29};
        vecs[6] = '{dd: 4'd15, dv: 4'd15, q: 4'd1,  r: 4'd0, dz: 1'b0, cyc: 29};
        vecs[7] = '{dd: 4'd1,  dv: 4'd15, q: 4'd0,  r: 4'd1, dz: 1'b0, cyc: 29};

        rst        = 1'b1;
        start      = 1'b0;
        dividend   = '0;
        divisor    = '0;
        start8     = 1'b0;
        dividend8  = '0;
        divisor8   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset quotient", quotient, 0);
        check("reset remainder", remainder, 0);
        check("reset div_by_zero", div_by_zero, 0);

        // Table-driven vectors, issued back-to-back.
        for (int i = 0; i < 8; i++) begin
            do_div(vecs[i].dd, vecs[i].dv, q, r, dz, dcyc, bcnt);
            check($sformatf("vec%0d quotient", i), q, vecs[i].q);
            check($sformatf("vec%0d remainder", i), r, vecs[i].r);
            check($sformatf("vec%0d div_by_zero", i), dz, vecs[i].dz);
            check($sformatf("vec%0d done cycle", i), dcyc, vecs[i].cyc);
            check($sformatf("vec%0d busy cycles", i), bcnt, vecs[i].cyc);
            check($sformatf("vec%0d done after", i), done, 0);
            check($sformatf("vec%0d busy after", i), busy, 0);
        end

        // start held high with changing operands: one result, then a new accept.
        start    = 1'b1;
        dividend = 4'd13;
        divisor  = 4'd3;
        @(posedge clk);
        #1;
        dividend = 4'd2;
        divisor  = 4'd2;
        ndone = 0;
        first = -1;
        qv    = '0;
        rv    = '0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (first < 0) first = n;
                qv = quotient;
                rv = remainder;
            end
            if (n == 30) check("held start idle gap busy", busy, 0);
        end
        check("held start done count", ndone, 1);
        check("held start done cycle", first, 29);
        check("held start quotient", qv, 4);
        check("held start remainder", rv, 1);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("held start reaccept busy", busy, 1);
        first = -1;
        for (int n = 32; n <= 200; n++) begin
            @(negedge clk);
            if (done) begin
                first = n;
                qv = quotient;
                rv = remainder;
                break;
            end
        end
        check("second op done cycle", first, 59);
        check("second op quotient", qv, 1);
        check("second op remainder", rv, 0);
        @(posedge clk);
        #1;

        // Reset in the middle of 14/4.
        start    = 1'b1;
        dividend = 4'd14;
        divisor  = 4'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("midop busy before rst", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midop rst busy", busy, 0);
        check("midop rst done", done, 0);
        check("midop rst quotient", quotient, 0);
        check("midop rst remainder", remainder, 0);
        check("midop rst div_by_zero", div_by_zero, 0);
        ndone = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("midop no activity after rst", ndone, 0);
        @(posedge clk);
        #1;
        do_div(4'd14, 4'd4, q, r, dz, dcyc, bcnt);
        check("after rst quotient", q, 3);
        check("after rst remainder", r, 2);
        check("after rst done cycle", dcyc, 29);

        // rst and start together: rst wins.
        rst      = 1'b1;
        start    = 1'b1;
        dividend = 4'd5;
        divisor  = 4'd1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        check("rst+start busy", busy, 0);
        @(posedge clk);
        #1;
        check("rst+start still idle", busy, 0);

        // Exhaustive 4-bit sweep against a reference model.
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                logic [3:0] eq, er;
                logic       edz;
                if (y == 0) begin
                    eq  = 4'hF;
                    er  = 4'(x);
                    edz = 1'b1;
                end else begin
                    eq  = 4'(x / y);
                    er  = 4'(x % y);
                    edz = 1'b0;
                end
                do_div(4'(x), 4'(y), q, r, dz, dcyc, bcnt);
                check($sformatf("sweep %0d/%0d quotient", x, y), q, eq);
                check($sformatf("sweep %0d/%0d remainder", x, y), r, er);
                check($sformatf("sweep %0d/%0d div_by_zero", x, y), dz, edz);
                check($sformatf("sweep %0d/%0d done cycle", x, y), dcyc, (y == 0) ? 1 : 29);
            end
        end

        // 8-bit instance spot check.
        start8    = 1'b1;
        dividend8 = 8'd255;
        divisor8  = 8'd16;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        first  = -1;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (done8) begin
                first = n;
                check("w8 quotient", quotient8, 15);
                check("w8 remainder", remainder8, 15);
                check("w8 div_by_zero", div_by_zero8, 0);
                break;
            end
        end
        check("w8 done cycle", first, 89);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_div_ctrl.md
Name: serial_div_ctrl

Overview:
- Unsigned restoring divider whose trial subtraction runs bit-serially through a single internally instantiated full_add cell, one bit per clock.
- The block holds the FSM that sequences the shared full-adder cell, plus the carry flip-flop, A/Q/M/T registers and counters.
- It is the sequential division engine of the project. A host starts it with a start/busy/done handshake.

Parameters:
- WIDTH, 4, operand, quotient and remainder width in bits (≥2).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, request a division. Sampled only in IDLE.
- dividend, input, WIDTH, unsigned dividend. Latched when start is accepted.
- divisor, input, WIDTH, unsigned divisor. Latched when start is accepted.
- busy, output, 1, high in every state except IDLE.
- done, output, 1, one-cycle pulse when a result is valid.
- quotient, output, WIDTH, registered result. Held until the next completion.
- remainder, output, WIDTH, registered result. Held until the next completion.
- div_by_zero, output, 1, set on completion of a zero-divisor request. Cleared when the next start is accepted.

Behaviour:
- Reset (clk edge with rst=1): FSM goes to IDLE. busy, done, quotient, remainder and div_by_zero are all 0. Internal A, Q, M, T, carry and counters are 0.
- Registers: A is WIDTH+1 bits (partial remainder). Q is WIDTH bits (dividend/quotient). M is WIDTH+1 bits (zero-extended divisor). T is WIDTH+1 bits (trial difference). cy is 1 bit (carry). it is the iteration counter. b is the bit counter.
- IDLE, start=1:
  - Latch Q=dividend, M={0,divisor}, A=0, it=0.
  - If divisor==0, go to DONE with a zero-divide flag.
  - Otherwise go to SHIFT.
- IDLE, start=0: stay in IDLE.
- SHIFT (1 cycle): {A,Q} <= {A,Q}<<1, b=0, cy=1 (two's-complement subtract), then go to SUB.
- SUB (WIDTH+1 cycles): each cycle the full_add inputs are a=A[b], b=~M[b], c=cy.
  - T[b] <= sum, cy <= carry, b <= b+1.
  - Leave SUB after the cycle with b==WIDTH and go to DECIDE.
- DECIDE (1 cycle):
  - cy==1 (A≥M): A <= T, Q[0] <= 1.
  - cy==0: A unchanged (restore), Q[0] <= 0.
  - it <= it+1. Go to DONE if it==WIDTH-1, else go to SHIFT.
- DONE (1 cycle): done=1, then go to IDLE.
  - Normal division: quotient=Q, remainder=A[WIDTH-1:0], div_by_zero=0.
  - Zero divide: quotient=all ones, remainder=dividend, div_by_zero=1.
  - The output registers load on the edge entering DONE, so values are valid in the same cycle as done.
- Latency: let edge 0 be the edge that samples start in IDLE.
  - Normal division: done is high in cycle WIDTH*(WIDTH+3)+1, which is cycle 29 for WIDTH=4. busy is high for WIDTH*(WIDTH+3)+1 cycles.
  - Zero divide: done is high in cycle 1.
- start while busy (including the DONE cycle) is ignored and not queued. A new start is accepted at the earliest in the cycle after done.
- dividend and divisor changes after acceptance have no effect on the running operation.
- rst mid-operation: the operation is abandoned. Next cycle is IDLE with all outputs 0. No done pulse.
- rst and start in the same cycle: rst wins and start is dropped.
- Arithmetic: all values unsigned. The WIDTH+1-bit A/T path prevents overflow on the shift. The final carry out of the WIDTH+1-bit serial add is the no-borrow indicator. The full_add cell is the only adder in the block; there is no parallel subtractor.

Test Plan:
- WIDTH=4, dividend=13, divisor=3, start pulsed 1 cycle -> busy high 29 cycles, done in cycle 29, quotient=4, remainder=1, div_by_zero=0.
- 15/1 -> q=15 r=0. 7/9 -> q=0 r=7. 0/5 -> q=0 r=0. All with done in cycle 29.
- 9/0 -> done in cycle 1, quotient=4'hF, remainder=9, div_by_zero=1. A following 8/2 -> q=4 r=0 and div_by_zero cleared.
- Start 13/3, then hold start=1 and drive dividend=2, divisor=2 throughout -> exactly one done (q=4 r=1). The next division is accepted only after the done cycle.
- Start 14/4, assert rst at cycle 10 -> next cycle busy=0, q=r=0, no done. Then 14/4 -> q=3 r=2.
- Exhaustive WIDTH=4, all 256 operand pairs back-to-back vs reference model. WIDTH=8 spot check 255/16 -> q=15 r=15, done in cycle 89.
